// File: rtl/ds_terrain_gen_if.sv
// Point stream carried from the terrain generator to its consumer:
// one (x,y,z) grid point per valid/ready handshake, last marks the final point.
interface ds_terrain_gen_if #(
    parameter int COORD_W = 10,
    parameter int Z_WIDTH = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [Z_WIDTH-1:0] z;
    logic               last;

    modport master (output out_valid, x, y, z, last, input out_ready);
    modport slave  (input out_valid, x, y, z, last, output out_ready);
endinterface

// File: rtl/ds_terrain_gen.sv
// Diamond-square heightmap generator: fills a (2^DIM_POWER+1)^2 grid in internal RAM,
// then streams every point in raster order over the ds_terrain_gen_if master port.
module ds_terrain_gen #(
    parameter int DIM_POWER   = 3,
    parameter int COORD_W     = 10,
    parameter int Z_WIDTH     = 8,
    parameter int ROUGH_SHIFT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         seed,
    input  logic [Z_WIDTH-1:0]  corner_init,
    output logic                busy,
    ds_terrain_gen_if.master    stream
);
    localparam int SIDE   = (1 << DIM_POWER) + 1;
    localparam int NPTS   = SIDE * SIDE;
    localparam int ADDR_W = $clog2(NPTS);
    localparam int IW     = DIM_POWER + 2;
    localparam logic [IW-1:0] S_I    = IW'(SIDE - 1);
    localparam logic [IW-1:0] ZERO_I = {IW{1'b0}};
    localparam logic [IW-1:0] ONE_I  = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CORNERS = 3'd1,
        ST_DIAMOND = 3'd2,
        ST_SQUARE  = 3'd3,
        ST_STREAM  = 3'd4
    } state_t;

    state_t             state_r;
    logic [2:0]         phase_r;
    logic [IW-1:0]      cx_r, cy_r, step_r, sx_r, sy_r;
    logic [3:0]         level_r;
    logic [15:0]        lfsr_r;
    logic [Z_WIDTH-1:0] corner_r;
    logic [Z_WIDTH+1:0] sum_r;
    logic [Z_WIDTH-1:0] value_r;
    logic               busy_r, out_valid_r, last_r;
    logic [COORD_W-1:0] x_r, y_r;
    logic [Z_WIDTH-1:0] z_r;

    logic [Z_WIDTH-1:0] mem_r [0:NPTS-1];

    logic [IW-1:0]      half_s, nb_x_s, nb_y_s;
    logic               row_aligned_s;
    logic [ADDR_W-1:0]  rd_addr_s, wr_addr_s;
    logic [Z_WIDTH-1:0] rd_data_s, wr_data_s;
    logic               wr_en_s;
    logic [15:0]        lfsr_next_s;
    logic [31:0]        shamt_s;
    logic [Z_WIDTH-2:0] mag_raw_s;
    logic [Z_WIDTH-1:0] mag_s, value_s;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IW-1:0] ax, input logic [IW-1:0] ay);
        addr_of = ADDR_W'(32'(ay) * 32'(SIDE) + 32'(ax));
    endfunction

    // Offset is subtracted when neg=1; result clamps to the representable range.
    function automatic logic [Z_WIDTH-1:0] apply_offset(input logic [Z_WIDTH-1:0] avg,
                                                        input logic neg,
                                                        input logic [Z_WIDTH-1:0] mag);
        logic [Z_WIDTH:0] t;
        t = {1'b0, avg} + {1'b0, mag};
        if (neg) begin
            apply_offset = (avg >= mag) ? (avg - mag) : {Z_WIDTH{1'b0}};
        end else begin
            apply_offset = t[Z_WIDTH] ? {Z_WIDTH{1'b1}} : t[Z_WIDTH-1:0];
        end
    endfunction

    // Neighbour coordinate for the current read phase; off-grid square neighbours mirror.
    always_comb begin
        half_s        = step_r >> 1;
        row_aligned_s = ((cy_r & (step_r - ONE_I)) == ZERO_I);
        nb_x_s        = cx_r;
        nb_y_s        = cy_r;
        if (state_r == ST_DIAMOND) begin
            case (phase_r)
                3'd0:    begin nb_x_s = cx_r - half_s; nb_y_s = cy_r - half_s; end
                3'd1:    begin nb_x_s = cx_r + half_s; nb_y_s = cy_r - half_s; end
                3'd2:    begin nb_x_s = cx_r - half_s; nb_y_s = cy_r + half_s; end
                default: begin nb_x_s = cx_r + half_s; nb_y_s = cy_r + half_s; end
            endcase
        end else begin
            case (phase_r)
                3'd0:    nb_y_s = (cy_r >= half_s) ? (cy_r - half_s) : (cy_r + half_s);
                3'd1:    nb_y_s = ((cy_r + half_s) <= S_I) ? (cy_r + half_s) : (cy_r - half_s);
                3'd2:    nb_x_s = (cx_r >= half_s) ? (cx_r - half_s) : (cx_r + half_s);
                default: nb_x_s = ((cx_r + half_s) <= S_I) ? (cx_r + half_s) : (cx_r - half_s);
            endcase
        end
    end

    // RAM read/write port steering and next-value arithmetic.
    always_comb begin
        if (state_r == ST_STREAM) begin
            rd_addr_s = addr_of(sx_r, sy_r);
        end else begin
            rd_addr_s = addr_of(nb_x_s, nb_y_s);
        end
        rd_data_s = mem_r[rd_addr_s];

        wr_en_s   = 1'b0;
        wr_addr_s = addr_of(cx_r, cy_r);
        wr_data_s = value_r;
        if (state_r == ST_CORNERS) begin
            wr_en_s   = 1'b1;
            wr_data_s = corner_r;
            case (phase_r)
                3'd0:    wr_addr_s = addr_of(ZERO_I, ZERO_I);
                3'd1:    wr_addr_s = addr_of(S_I, ZERO_I);
                3'd2:    wr_addr_s = addr_of(ZERO_I, S_I);
                default: wr_addr_s = addr_of(S_I, S_I);
            endcase
        end else if (((state_r == ST_DIAMOND) || (state_r == ST_SQUARE)) && (phase_r == 3'd5)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end

        lfsr_next_s = lfsr_step(lfsr_r);
        shamt_s     = 32'(ROUGH_SHIFT) + 32'(level_r);
        mag_raw_s   = lfsr_next_s[Z_WIDTH-2:0] >> shamt_s;
        mag_s       = {1'b0, mag_raw_s};
        value_s     = apply_offset(sum_r[Z_WIDTH+1:2], lfsr_next_s[Z_WIDTH-1], mag_s);
    end

    // Heightmap storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Control FSM: generation sequencing plus registered stream outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            phase_r     <= 3'd0;
            cx_r        <= ZERO_I;
            cy_r        <= ZERO_I;
            step_r      <= ZERO_I;
            sx_r        <= ZERO_I;
            sy_r        <= ZERO_I;
            level_r     <= 4'd0;
            lfsr_r      <= 16'h0001;
            corner_r    <= {Z_WIDTH{1'b0}};
            sum_r       <= {(Z_WIDTH+2){1'b0}};
            value_r     <= {Z_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
            x_r         <= {COORD_W{1'b0}};
            y_r         <= {COORD_W{1'b0}};
            z_r         <= {Z_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        lfsr_r   <= (seed == 16'h0000) ? 16'h0001 : seed;
                        corner_r <= corner_init;
                        step_r   <= S_I;
                        level_r  <= 4'd0;
                        phase_r  <= 3'd0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_CORNERS;
                    end
                end
                ST_CORNERS: begin
                    if (phase_r == 3'd3) begin
                        phase_r <= 3'd0;
                        cx_r    <= S_I >> 1;
                        cy_r    <= S_I >> 1;
                        state_r <= ST_DIAMOND;
                    end else begin
                        phase_r <= phase_r + 3'd1;
                    end
                end
                ST_DIAMOND, ST_SQUARE: begin
                    if (phase_r < 3'd4) begin
                        sum_r   <= ((phase_r == 3'd0) ? {(Z_WIDTH+2){1'b0}} : sum_r) + {2'b00, rd_data_s};
                        phase_r <= phase_r + 3'd1;
                    end else if (phase_r == 3'd4) begin
                        value_r <= value_s;
                        lfsr_r  <= lfsr_next_s;
                        phase_r <= 3'd5;
                    end else begin
                        phase_r <= 3'd0;
                        if ((cx_r + step_r) <= S_I) begin
                            cx_r <= cx_r + step_r;
                        end else if (state_r == ST_DIAMOND) begin
                            if ((cy_r + step_r) <= S_I) begin
                                cx_r <= half_s;
                                cy_r <= cy_r + step_r;
                            end else begin
                                state_r <= ST_SQUARE;
                                cx_r    <= half_s;
                                cy_r    <= ZERO_I;
                            end
                        end else if ((cy_r + half_s) <= S_I) begin
                            // Square rows alternate between x=half and x=0 starts.
                            cy_r <= cy_r + half_s;
                            cx_r <= row_aligned_s ? ZERO_I : half_s;
                        end else begin
                            step_r  <= half_s;
                            level_r <= level_r + 4'd1;
                            if (half_s > ONE_I) begin
                                state_r <= ST_DIAMOND;
                                cx_r    <= half_s >> 1;
                                cy_r    <= half_s >> 1;
                            end else begin
                                state_r <= ST_STREAM;
                                sx_r    <= ZERO_I;
                                sy_r    <= ZERO_I;
                            end
                        end
                    end
                end
                ST_STREAM: begin
                    if (out_valid_r && stream.out_ready && last_r) begin
                        out_valid_r <= 1'b0;
                        last_r      <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (!out_valid_r || stream.out_ready) begin
                        x_r         <= COORD_W'(sx_r);
                        y_r         <= COORD_W'(sy_r);
                        z_r         <= rd_data_s;
                        last_r      <= (sx_r == S_I) && (sy_r == S_I);
                        out_valid_r <= 1'b1;
                        if (sx_r == S_I) begin
                            sx_r <= ZERO_I;
                            sy_r <= sy_r + ONE_I;
                        end else begin
                            sx_r <= sx_r + ONE_I;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_r;
    assign stream.out_valid = out_valid_r;
    assign stream.x         = x_r;
    assign stream.y         = y_r;
    assign stream.z         = z_r;
    assign stream.last      = last_r;
endmodule
